mult_carry_normalizer: RTL



---
 rtl/mult_carry_normalizer.sv | 114 +++++++++++
 1 files changed

// File: rtl/mult_carry_normalizer.sv
// rtl/mult_carry_normalizer.sv - serial carry normalizer for redundant multiplier limbs (optional MULT_NORM_PINGPONG_EN shadow buffer)
module mult_carry_normalizer #(
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17,
    parameter int WORD_LEN     = 16,
    localparam int L           = NUM_ELEMENTS * 2,
    localparam int IW          = $clog2(NUM_ELEMENTS * 2),
    localparam int CW          = BIT_LEN - WORD_LEN + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_LEN-1:0]  in_M [L],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] out_word,
    output logic [IW-1:0]       out_idx,
    output logic                out_last,
    output logic [CW-1:0]       out_carry
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [BIT_LEN-1:0] limb_buf [L];
    logic [CW-1:0]      carry;
    logic [IW-1:0]      idx;
    logic [BIT_LEN:0]   sum;
    logic               run;
    logic               idx_last;
    logic               accept;
    logic               in_fire;

`ifdef MULT_NORM_PINGPONG_EN
    logic [BIT_LEN-1:0] shadow_buf [L];
    logic               shadow_full;
`endif

    // Current word: the buffered limb plus the carry rippled in from the word below
    always_comb begin
        run      = (state == RUN);
        sum      = {1'b0, limb_buf[idx]} + (BIT_LEN + 1)'(carry);
        idx_last = (idx == IW'(L - 1));
        accept   = run && out_ready;
`ifdef MULT_NORM_PINGPONG_EN
        in_ready = !shadow_full;
`else
        in_ready = (state == IDLE);
`endif
        in_fire   = in_valid && in_ready;
        out_valid = run;
        out_word  = run ? sum[WORD_LEN-1:0] : '0;
        out_idx   = idx;
        out_last  = run && idx_last;
        out_carry = (run && idx_last) ? sum[BIT_LEN:WORD_LEN] : '0;
    end

    // Capture, carry propagation and (optionally) shadow buffer handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            carry <= '0;
            idx   <= '0;
            for (int i = 0; i < L; i++) begin
                limb_buf[i] <= '0;
            end
`ifdef MULT_NORM_PINGPONG_EN
            shadow_full <= 1'b0;
            for (int i = 0; i < L; i++) begin
                shadow_buf[i] <= '0;
            end
`endif
        end else begin
            if (state == IDLE) begin
                if (in_fire) begin
                    limb_buf <= in_M;
                    carry    <= '0;
                    idx      <= '0;
                    state    <= RUN;
                end
            end else if (accept) begin
                if (idx_last) begin
                    carry <= '0;
                    idx   <= '0;
`ifdef MULT_NORM_PINGPONG_EN
                    // A queued transaction or one arriving on this very cycle restarts at word 0 with no gap
                    if (shadow_full) begin
                        limb_buf    <= shadow_buf;
                        shadow_full <= 1'b0;
                    end else if (in_fire) begin
                        limb_buf <= in_M;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end else begin
                    carry <= sum[BIT_LEN:WORD_LEN];
                    idx   <= idx + 1'b1;
                end
            end
`ifdef MULT_NORM_PINGPONG_EN
            // Input taken mid-transaction is parked until the active one drains
            if (run && in_fire && !(accept && idx_last)) begin
                shadow_buf  <= in_M;
                shadow_full <= 1'b1;
            end
`endif
        end
    end

endmodule
